// File: rtl/vga_text_renderer.sv
// Text-mode pixel generator: turns VGA timing (hPos/vPos/bright/syncs) into
// RGB for an 80x30 screen of 8x16 glyphs fetched from external synchronous
// character RAM and font ROM, with a blinking underline cursor. Three pixel
// ticks of latency; syncs and bright are delayed to stay aligned with rgb.
module vga_text_renderer #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        clkEnable,
  input  logic [9:0]  hPos,
  input  logic [8:0]  vPos,
  input  logic        bright,
  input  logic        hSyncIn,
  input  logic        vSyncIn,
  output logic [11:0] charAddr,
  input  logic [15:0] charData,
  output logic [11:0] fontAddr,
  input  logic [7:0]  fontData,
  input  logic [6:0]  cursorCol,
  input  logic [4:0]  cursorRow,
  input  logic        cursorEn,
  output logic [7:0]  rgb,
  output logic        hSyncOut,
  output logic        vSyncOut,
  output logic        brightOut
);

  localparam int unsigned AW = 12;
  localparam int unsigned CW = 3;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Stage 0 registers (address issue)
  logic [AW-1:0] char_addr_q, char_addr_d;
  logic [2:0]    col3_s0_q, col3_s0_d;
  logic [3:0]    grow_s0_q, grow_s0_d;
  logic          hit_s0_q, hit_s0_d;
  logic          bright_s0_q, bright_s0_d;
  logic          hs_s0_q, hs_s0_d;
  logic          vs_s0_q, vs_s0_d;

  // Stage 1 registers (font address issue, colour latch)
  logic [AW-1:0] font_addr_q, font_addr_d;
  logic [CW-1:0] fg_s1_q, fg_s1_d;
  logic [CW-1:0] bg_s1_q, bg_s1_d;
  logic [2:0]    col3_s1_q, col3_s1_d;
  logic [3:0]    grow_s1_q, grow_s1_d;
  logic          hit_s1_q, hit_s1_d;
  logic          bright_s1_q, bright_s1_d;
  logic          hs_s1_q, hs_s1_d;
  logic          vs_s1_q, vs_s1_d;

  // Output registers
  logic [7:0]    rgb_q, rgb_d;
  logic          bright_out_q, bright_out_d;
  logic          hs_out_q, hs_out_d;
  logic          vs_out_q, vs_out_d;

  // Cursor blink state
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Combinational helpers
  logic [AW-1:0] addr_c;
  logic          hit_c;
  logic          vs_fall_c;
  logic [2:0]    bit_idx_c;
  logic          pixel_c;
  logic [CW-1:0] colour_c;
  logic          unused_ok;

  // Upper RAM word bits carry no meaning for rendering
  assign unused_ok = &{1'b0, charData[15:14]};

  // Cell address, cursor match, sync edge and pixel selection
  always_comb begin
    addr_c    = AW'(vPos[8:4]) * AW'(COLS) + AW'(hPos[9:3]);
    hit_c     = cursorEn
              && (32'(cursorCol) < COLS) && (32'(cursorRow) < ROWS)
              && (hPos[9:3] == cursorCol) && (vPos[8:4] == cursorRow);
    vs_fall_c = vs_s0_q & ~vSyncIn;
    bit_idx_c = 3'(3'd7 - col3_s1_q);
    pixel_c   = fontData[bit_idx_c]
              | (hit_s1_q & (grow_s1_q[3:1] == 3'b111) & phase_q);
    colour_c  = pixel_c ? fg_s1_q : bg_s1_q;
  end

  // Next-state for the whole pipeline; everything holds unless clkEnable
  always_comb begin
    char_addr_d  = char_addr_q;
    col3_s0_d    = col3_s0_q;
    grow_s0_d    = grow_s0_q;
    hit_s0_d     = hit_s0_q;
    bright_s0_d  = bright_s0_q;
    hs_s0_d      = hs_s0_q;
    vs_s0_d      = vs_s0_q;
    font_addr_d  = font_addr_q;
    fg_s1_d      = fg_s1_q;
    bg_s1_d      = bg_s1_q;
    col3_s1_d    = col3_s1_q;
    grow_s1_d    = grow_s1_q;
    hit_s1_d     = hit_s1_q;
    bright_s1_d  = bright_s1_q;
    hs_s1_d      = hs_s1_q;
    vs_s1_d      = vs_s1_q;
    rgb_d        = rgb_q;
    bright_out_d = bright_out_q;
    hs_out_d     = hs_out_q;
    vs_out_d     = vs_out_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;

    if (clkEnable) begin
      char_addr_d  = addr_c;
      col3_s0_d    = hPos[2:0];
      grow_s0_d    = vPos[3:0];
      hit_s0_d     = hit_c;
      bright_s0_d  = bright;
      hs_s0_d      = hSyncIn;
      vs_s0_d      = vSyncIn;

      font_addr_d  = {charData[7:0], grow_s0_q};
      fg_s1_d      = charData[10:8];
      bg_s1_d      = charData[13:11];
      col3_s1_d    = col3_s0_q;
      grow_s1_d    = grow_s0_q;
      hit_s1_d     = hit_s0_q;
      bright_s1_d  = bright_s0_q;
      hs_s1_d      = hs_s0_q;
      vs_s1_d      = vs_s0_q;

      rgb_d        = bright_s1_q
                   ? {colour_c[2], colour_c[2], colour_c[2],
                      colour_c[1], colour_c[1], colour_c[1],
                      colour_c[0], colour_c[0]}
                   : 8'h00;
      bright_out_d = bright_s1_q;
      hs_out_d     = hs_s1_q;
      vs_out_d     = vs_s1_q;

      if (vs_fall_c) begin
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = BW'(blink_cnt_q + 1'b1);
        end
      end
    end
  end

  // State registers; sync delay lines reset to the inactive (high) level
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      char_addr_q  <= '0;
      col3_s0_q    <= '0;
      grow_s0_q    <= '0;
      hit_s0_q     <= 1'b0;
      bright_s0_q  <= 1'b0;
      hs_s0_q      <= 1'b1;
      vs_s0_q      <= 1'b1;
      font_addr_q  <= '0;
      fg_s1_q      <= '0;
      bg_s1_q      <= '0;
      col3_s1_q    <= '0;
      grow_s1_q    <= '0;
      hit_s1_q     <= 1'b0;
      bright_s1_q  <= 1'b0;
      hs_s1_q      <= 1'b1;
      vs_s1_q      <= 1'b1;
      rgb_q        <= '0;
      bright_out_q <= 1'b0;
      hs_out_q     <= 1'b1;
      vs_out_q     <= 1'b1;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else begin
      char_addr_q  <= char_addr_d;
      col3_s0_q    <= col3_s0_d;
      grow_s0_q    <= grow_s0_d;
      hit_s0_q     <= hit_s0_d;
      bright_s0_q  <= bright_s0_d;
      hs_s0_q      <= hs_s0_d;
      vs_s0_q      <= vs_s0_d;
      font_addr_q  <= font_addr_d;
      fg_s1_q      <= fg_s1_d;
      bg_s1_q      <= bg_s1_d;
      col3_s1_q    <= col3_s1_d;
      grow_s1_q    <= grow_s1_d;
      hit_s1_q     <= hit_s1_d;
      bright_s1_q  <= bright_s1_d;
      hs_s1_q      <= hs_s1_d;
      vs_s1_q      <= vs_s1_d;
      rgb_q        <= rgb_d;
      bright_out_q <= bright_out_d;
      hs_out_q     <= hs_out_d;
      vs_out_q     <= vs_out_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
    end
  end

  assign charAddr  = char_addr_q;
  assign fontAddr  = font_addr_q;
  assign rgb       = rgb_q;
  assign hSyncOut  = hs_out_q;
  assign vSyncOut  = vs_out_q;
  assign brightOut = bright_out_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer with synchronous RAM/ROM models.
module tb_vga_text_renderer;

  logic        clk;
  logic        clr;
  logic        clkEnable;
  logic [9:0]  hPos;
  logic [8:0]  vPos;
  logic        bright;
  logic        hSyncIn;
  logic        vSyncIn;
  logic [11:0] charAddr;
  logic [15:0] charData;
  logic [11:0] fontAddr;
  logic [7:0]  fontData;
  logic [6:0]  cursorCol;
  logic [4:0]  cursorRow;
  logic        cursorEn;
  logic [7:0]  rgb;
  logic        hSyncOut;
  logic        vSyncOut;
  logic        brightOut;

  int total;
  int bad;

  logic [15:0] cram [0:4095];
  logic [7:0]  from [0:4095];

  vga_text_renderer #(.COLS(80), .ROWS(30), .BLINK_FRAMES(2)) dut (
    .clk(clk), .clr(clr), .clkEnable(clkEnable),
    .hPos(hPos), .vPos(vPos), .bright(bright),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
    .charAddr(charAddr), .charData(charData),
    .fontAddr(fontAddr), .fontData(fontData),
    .cursorCol(cursorCol), .cursorRow(cursorRow), .cursorEn(cursorEn),
    .rgb(rgb), .hSyncOut(hSyncOut), .vSyncOut(vSyncOut), .brightOut(brightOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: one clk of read latency
  always @(posedge clk) begin
    charData <= cram[charAddr];
    fontData <= from[fontAddr];
  end

  // One pixel tick: an enabled edge followed by an idle edge
  task automatic tick();
    clkEnable = 1'b1;
    @(posedge clk); #1;
    clkEnable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    hPos = '0; vPos = '0; bright = 1'b0; hSyncIn = 1'b1; vSyncIn = 1'b1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    idle_inputs();
    repeat (2) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hPos = 10'($urandom_range(0, 639)); vPos = 9'($urandom_range(0, 479));
      bright = 1'($urandom); hSyncIn = 1'($urandom); vSyncIn = 1'($urandom);
      clkEnable = 1'($urandom);
      @(posedge clk); #1;
      total++;
      if (rgb !== 8'h00 || hSyncOut !== 1'b1 || vSyncOut !== 1'b1 ||
          brightOut !== 1'b0 || charAddr !== 12'd0 || fontAddr !== 12'd0) begin
        bad++;
        $display("FAIL reset: rgb=%h hs=%b vs=%b br=%b ca=%0d fa=%h exp 00 1 1 0 0 0",
                 rgb, hSyncOut, vSyncOut, brightOut, charAddr, fontAddr);
      end
    end
    clkEnable = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addr();
    cram[162] = 16'h0C41;
    hPos = 10'd17; vPos = 9'd35; bright = 1'b1;
    tick();
    total++;
    if (charAddr !== 12'd162) begin
      bad++; $display("FAIL addr_char: got=%0d exp=162", charAddr);
    end
    idle_inputs();
    tick();
    total++;
    if (fontAddr !== 12'h413) begin
      bad++; $display("FAIL addr_font: got=%h exp=413", fontAddr);
    end
    tick();
  endtask

  task automatic test_pixel();
    from[12'h413] = 8'h80;
    hPos = 10'd16; vPos = 9'd35; bright = 1'b1;
    tick();
    hPos = 10'd17;
    tick();
    idle_inputs();
    tick();
    total++;
    if (rgb !== 8'hE0) begin bad++; $display("FAIL pix_col0: got=%h exp=e0", rgb); end
    tick();
    total++;
    if (rgb !== 8'h03) begin bad++; $display("FAIL pix_col1: got=%h exp=03", rgb); end
    tick();
    total++;
    if (rgb !== 8'h00) begin bad++; $display("FAIL pix_blank_after: got=%h exp=00", rgb); end
  endtask

  task automatic test_blanking();
    cram[0] = 16'h07FF;
    from[12'hFF0] = 8'hFF;
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (rgb !== 8'h00 || brightOut !== 1'b0) begin
      bad++; $display("FAIL blank: rgb=%h br=%b exp 00 0", rgb, brightOut);
    end
    bright = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (rgb !== 8'hFF || brightOut !== 1'b1) begin
      bad++; $display("FAIL unblank: rgb=%h br=%b exp ff 1", rgb, brightOut);
    end
  endtask

  task automatic test_align();
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
    hSyncIn = 1'b0; bright = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (hSyncOut !== (i < 3) || brightOut !== (i == 3)) begin
        bad++;
        $display("FAIL align_t%0d: hs=%b br=%b exp %b %b", i, hSyncOut, brightOut,
                 1'(i < 3), 1'(i == 3));
      end
    end
    total++;
    if (rgb !== 8'hFF) begin bad++; $display("FAIL align_rgb: got=%h exp=ff", rgb); end
    hSyncIn = 1'b1; bright = 1'b0; hPos = 10'd100; vPos = 9'd100;
    clkEnable = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    total++;
    if (hSyncOut !== 1'b0 || brightOut !== 1'b1 || rgb !== 8'hFF || charAddr !== 12'd0) begin
      bad++;
      $display("FAIL freeze: hs=%b br=%b rgb=%h ca=%0d exp 0 1 ff 0",
               hSyncOut, brightOut, rgb, charAddr);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic render(input logic [9:0] h, input logic [8:0] v);
    hPos = h; vPos = v; bright = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic vsync_pulse();
    vSyncIn = 1'b0;
    tick();
    vSyncIn = 1'b1;
    tick();
  endtask

  task automatic test_cursor();
    logic [7:0] exp_v;
    do_reset();
    cram[165] = 16'h0220;
    cursorEn = 1'b1; cursorCol = 7'd5; cursorRow = 5'd2;
    for (int f = 0; f < 6; f++) begin
      exp_v = (f == 2 || f == 3) ? 8'h1C : 8'h00;
      render(10'd42, 9'd46);
      total++;
      if (rgb !== exp_v) begin bad++; $display("FAIL cur_f%0d_r14: got=%h exp=%h", f, rgb, exp_v); end
      render(10'd47, 9'd47);
      total++;
      if (rgb !== exp_v) begin bad++; $display("FAIL cur_f%0d_r15: got=%h exp=%h", f, rgb, exp_v); end
      render(10'd42, 9'd45);
      total++;
      if (rgb !== 8'h00) begin bad++; $display("FAIL cur_f%0d_r13: got=%h exp=00", f, rgb); end
      vsync_pulse();
    end
    // Six falls leave the phase visible again
    render(10'd42, 9'd46);
    total++;
    if (rgb !== 8'h1C) begin bad++; $display("FAIL cur_f6_on: got=%h exp=1c", rgb); end
    render(10'd48, 9'd46);
    total++;
    if (rgb !== 8'h00) begin bad++; $display("FAIL cur_neighbour: got=%h exp=00", rgb); end
    cursorCol = 7'd80;
    render(10'd642, 9'd46);
    total++;
    if (rgb !== 8'h00) begin bad++; $display("FAIL cur_col80: got=%h exp=00", rgb); end
    cursorCol = 7'd5; cursorEn = 1'b0;
    render(10'd42, 9'd46);
    total++;
    if (rgb !== 8'h00) begin bad++; $display("FAIL cur_disabled: got=%h exp=00", rgb); end
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 4096; i++) begin
      cram[i] = 16'h0000;
      from[i] = 8'h00;
    end
    clkEnable = 1'b0;
    cursorEn = 1'b0; cursorCol = '0; cursorRow = '0;
    clr = 1'b0;
    idle_inputs();
    test_reset();
    test_addr();
    test_pixel();
    test_blanking();
    test_align();
    test_cursor();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
